// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversampled recovery of 11-bit frames
// (start, 8 data, parity, stop) with start/stop/parity checking.
module uart_rx_deserializer #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_tick,
  input  logic        rx_in,
  output logic [10:0] frame_out,
  output logic [7:0]  data_out,
  output logic        frame_valid,
  output logic        parity_err,
  output logic        framing_err,
  output logic        rx_busy
);

  localparam int unsigned FRAME_W = 11;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned TICK_W  = $clog2(OVERSAMPLE);

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  STOP_IDX  = BIT_W'(9);

  typedef enum logic [1:0] {
    IDLE,
    START,
    BITS,
    WAIT_IDLE
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  // Holds the bits received so far; the incoming sample completes the frame.
  logic [FRAME_W-2:0]   shreg_q, shreg_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 framing_err_q, framing_err_d;
  logic                 rx_busy_q, rx_busy_d;
  logic [FRAME_W-1:0]   shreg_next;

  assign shreg_next = {shreg_q, rx_s_q};

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;

    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_d    = START;
            tick_cnt_d = '0;
          end
        end
        START: begin
          if (tick_cnt_q == HALF_LAST) begin
            if (rx_s_q) begin
              state_d = IDLE;
            end else begin
              shreg_d    = shreg_next[FRAME_W-2:0];
              bit_cnt_d  = '0;
              tick_cnt_d = '0;
              state_d    = BITS;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
        BITS: begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d = '0;
            shreg_d    = shreg_next[FRAME_W-2:0];
            bit_cnt_d  = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == STOP_IDX) begin
              frame_d       = shreg_next;
              frame_valid_d = 1'b1;
              parity_err_d  = ((^shreg_next[9:1]) != PARITY_ODD);
              framing_err_d = ~shreg_next[0];
              bit_cnt_d     = '0;
              state_d       = rx_s_q ? IDLE : WAIT_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s_q) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    rx_busy_d = (state_d != IDLE);
  end

  // State and output registers, including the two-flop line synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shreg_q       <= '1;
      frame_q       <= '1;
      frame_valid_q <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      rx_busy_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_meta_q     <= rx_in;
      rx_s_q        <= rx_meta_q;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      rx_busy_q     <= rx_busy_d;
    end
  end

  assign frame_out   = frame_q;
  assign data_out    = frame_q[9:2];
  assign frame_valid = frame_valid_q;
  assign parity_err  = parity_err_q;
  assign framing_err = framing_err_q;
  assign rx_busy     = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed frames, a queue-based
// frame model checked every cycle, and literal expectations per scenario.
module tb_uart_rx_deserializer;

  localparam int unsigned OS       = 16;
  localparam int unsigned TICK_DIV = 3;
  localparam int unsigned BIT_CLKS = OS * TICK_DIV;
  localparam bit          P_ODD    = 1'b0;

  logic        clk;
  logic        rst_n;
  logic        sample_tick;
  logic        rx_in;
  logic [10:0] frame_out;
  logic [7:0]  data_out;
  logic        frame_valid;
  logic        parity_err;
  logic        framing_err;
  logic        rx_busy;

  uart_rx_deserializer #(.OVERSAMPLE(OS), .PARITY_ODD(P_ODD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .rx_in       (rx_in),
    .frame_out   (frame_out),
    .data_out    (data_out),
    .frame_valid (frame_valid),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .rx_busy     (rx_busy)
  );

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];
  logic [10:0] cur_frame;
  logic        cur_perr;
  logic        cur_ferr;
  int          strobe_cnt = 0;
  int          cyc = 0;
  int          t_last = 0;
  int          t_prev = 0;
  logic [10:0] got_frame = '1;
  logic [10:0] prev_frame = '1;
  logic        got_perr = 1'b0;
  logic        got_ferr = 1'b0;
  int          base;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // sample_tick: one clk high out of every TICK_DIV.
  initial begin
    int div;
    div = 0;
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      div = (div == TICK_DIV - 1) ? 0 : div + 1;
      sample_tick = (div == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Even/odd parity error from the count of ones over data and parity bits.
  function automatic logic model_perr(input logic [10:0] f);
    int ones;
    ones = 0;
    for (int i = 1; i <= 9; i++) ones += int'(f[i]);
    return ((ones % 2) == 1) != P_ODD;
  endfunction

  // Per-cycle comparison against the model's current expected outputs.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      cur_frame = 11'h7FF;
      cur_perr  = 1'b0;
      cur_ferr  = 1'b0;
      chk("reset_frame_valid", 32'(frame_valid), 32'd0);
      chk("reset_rx_busy", 32'(rx_busy), 32'd0);
    end else if (frame_valid) begin
      strobe_cnt++;
      t_prev = t_last;
      t_last = cyc;
      prev_frame = got_frame;
      got_frame  = frame_out;
      got_perr   = parity_err;
      got_ferr   = framing_err;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got frame %0h expected no strobe at cycle %0d", frame_out, cyc);
      end else begin
        cur_frame = exp_q.pop_front();
        cur_perr  = model_perr(cur_frame);
        cur_ferr  = ~cur_frame[0];
      end
    end
    chk("frame_out", 32'(frame_out), 32'(cur_frame));
    chk("data_out", 32'(data_out), 32'(cur_frame[9:2]));
    chk("parity_err", 32'(parity_err), 32'(cur_perr));
    chk("framing_err", 32'(framing_err), 32'(cur_ferr));
  end

  task automatic hold_bits(input int n);
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [10:0] f);
    exp_q.push_back(f);
    for (int i = 10; i >= 0; i--) begin
      rx_in = f[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  initial begin
    cur_frame = 11'h7FF;
    cur_perr  = 1'b0;
    cur_ferr  = 1'b0;
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_frame_out", 32'(frame_out), 32'h7FF);
    chk("rst_data_out", 32'(data_out), 32'hFF);
    chk("rst_errs", 32'({parity_err, framing_err}), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    hold_bits(2);

    // 1: A5 with correct even parity
    base = strobe_cnt;
    send_frame(11'h295);
    hold_bits(2);
    chk("t1_strobes", 32'(strobe_cnt - base), 32'd1);
    chk("t1_frame", 32'(got_frame), 32'h295);
    chk("t1_data", 32'(got_frame[9:2]), 32'hA5);
    chk("t1_errs", 32'({got_perr, got_ferr}), 32'b00);

    // 2: parity bit flipped
    base = strobe_cnt;
    send_frame(11'h297);
    hold_bits(2);
    chk("t2_strobes", 32'(strobe_cnt - base), 32'd1);
    chk("t2_data", 32'(got_frame[9:2]), 32'hA5);
    chk("t2_errs", 32'({got_perr, got_ferr}), 32'b10);

    // 3: stop bit low, line held low 40 bit-times
    base = strobe_cnt;
    send_frame(11'h294);
    rx_in = 1'b0;
    hold_bits(40);
    chk("t3_busy_low_line", 32'(rx_busy), 32'd1);
    chk("t3_strobes", 32'(strobe_cnt - base), 32'd1);
    chk("t3_errs", 32'({got_perr, got_ferr}), 32'b01);
    rx_in = 1'b1;
    hold_bits(1);
    chk("t3_busy_after_high", 32'(rx_busy), 32'd0);
    chk("t3_strobes_after", 32'(strobe_cnt - base), 32'd1);
    hold_bits(1);

    // 4: five-tick low glitch
    base = strobe_cnt;
    rx_in = 1'b0;
    repeat (5 * TICK_DIV) @(negedge clk);
    rx_in = 1'b1;
    chk("t4_busy_during", 32'(rx_busy), 32'd1);
    hold_bits(1);
    chk("t4_busy_after", 32'(rx_busy), 32'd0);
    chk("t4_strobes", 32'(strobe_cnt - base), 32'd0);
    hold_bits(1);

    // 5: back-to-back 00 then FF
    base = strobe_cnt;
    send_frame(11'h001);
    send_frame(11'h3FD);
    hold_bits(2);
    chk("t5_strobes", 32'(strobe_cnt - base), 32'd2);
    chk("t5_spacing", 32'(t_last - t_prev), 32'(11 * BIT_CLKS));
    chk("t5_first_data", 32'(prev_frame[9:2]), 32'h00);
    chk("t5_second_data", 32'(got_frame[9:2]), 32'hFF);

    // 6: reset during data bit 4, then a clean 3C frame
    base = strobe_cnt;
    for (int i = 10; i >= 6; i--) begin
      rx_in = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    chk("t6_busy_before_rst", 32'(rx_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_frame_out", 32'(frame_out), 32'h7FF);
    chk("t6_rst_data_out", 32'(data_out), 32'hFF);
    chk("t6_rst_flags", 32'({frame_valid, parity_err, framing_err, rx_busy}), 32'd0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    hold_bits(2);
    chk("t6_no_strobe_on_rst", 32'(strobe_cnt - base), 32'd0);
    send_frame(11'h0F1);
    hold_bits(2);
    chk("t6_strobes", 32'(strobe_cnt - base), 32'd1);
    chk("t6_frame", 32'(got_frame), 32'h0F1);
    chk("t6_data", 32'(got_frame[9:2]), 32'h3C);
    chk("t6_errs", 32'({got_perr, got_ferr}), 32'b00);
    chk("model_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
